// File: rtl/shift_reg_unit_if.sv
// Bus bundle for shift_reg_unit: command/data inputs and register/status outputs.
// Master drives commands; slave (the register) returns contents and status.
interface shift_reg_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] data;
  logic             ser_in;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, data, ser_in, start, amount,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  en, mode, data, ser_in, start, amount,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/shift_reg_unit.sv
// Universal shift register: hold/load/shift/rotate/clear/asr single steps
// plus a multi-cycle "shift by N" command with busy/done handshake.
module shift_reg_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  shift_reg_unit_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_r, q_nx;
  logic             so_r, so_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       rmode, rmode_nx;
  logic             busy_r, busy_nx;
  logic             done_r, done_nx;

  logic [2:0]       op;
  logic [WIDTH-1:0] sq;
  logic             sso;

  // One step of the selected op; RUN uses the latched mode.
  assign op = (state == RUN) ? rmode : bus.mode;

  always_comb begin
    sq  = q_r;
    sso = so_r;
    case (op)
      3'b000: sq = q_r;
      3'b001: sq = bus.data;
      3'b010: begin
        sq  = {q_r[WIDTH-2:0], bus.ser_in};
        sso = q_r[WIDTH-1];
      end
      3'b011: begin
        sq  = {bus.ser_in, q_r[WIDTH-1:1]};
        sso = q_r[0];
      end
      3'b100: begin
        sq  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        sso = q_r[WIDTH-1];
      end
      3'b101: begin
        sq  = {q_r[0], q_r[WIDTH-1:1]};
        sso = q_r[0];
      end
      3'b110: sq = '0;
      default: begin
        sq  = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        sso = q_r[0];
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    q_nx     = q_r;
    so_nx    = so_r;
    cnt_nx   = cnt;
    rmode_nx = rmode;
    busy_nx  = busy_r;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        priority case (1'b1)
          bus.start: begin
            rmode_nx = bus.mode;
            if (bus.amount == '0) begin
              done_nx = 1'b1;
            end else begin
              cnt_nx   = bus.amount;
              busy_nx  = 1'b1;
              state_nx = RUN;
            end
          end
          bus.en: begin
            q_nx  = sq;
            so_nx = sso;
          end
          default: ;
        endcase
      end
      RUN: begin
        q_nx   = sq;
        so_nx  = sso;
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      q_r    <= '0;
      so_r   <= 1'b0;
      cnt    <= '0;
      rmode  <= 3'b000;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      q_r    <= q_nx;
      so_r   <= so_nx;
      cnt    <= cnt_nx;
      rmode  <= rmode_nx;
      busy_r <= busy_nx;
      done_r <= done_nx;
    end
  end

  assign bus.q       = q_r;
  assign bus.ser_out = so_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule
